// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Port ids double as the last_grant encoding and the response-tag owner field.
package mem_arbiter_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_A};

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant logic with a last-grant register: round-robin or fixed A priority.
// Latency: grants are combinational in the request cycle; last_grant updates on the following edge.
// Backpressure: a requester that loses simply sees no grant and must hold its request.
module rr_arb2
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_grant;
    logic prefer_a;

    // In fixed mode A always takes a conflict; otherwise A wins only if B went last.
    assign prefer_a = (FIXED_PRIO != 0) || (last_grant == PORT_B);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            gnt_a = req_a && (!req_b || prefer_a);
            gnt_b = req_b && (!req_a || !prefer_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_B;
        end else if (gnt_a) begin
            last_grant <= PORT_A;
        end else if (gnt_b) begin
            last_grant <= PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between ports A and B, one access per cycle.
// Latency: request accepted at T, memory op at T+1, x_rvalid/x_rdata at T+2 (writes return the written word).
// Backpressure: x_ready is the combinational grant; the losing port holds its request until granted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    logic                  gnt_a;
    logic                  gnt_b;
    logic                  xfer;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  we_q;
    tag_t                  tag_q [2];

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_req),
        .req_b (b_req),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign xfer    = gnt_a || gnt_b;

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (gnt_b) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Issue registers: address/data hold when idle, only the write enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            we_q <= xfer && sel_we;
            if (xfer) begin
                mem_addr <= sel_addr;
                mem_data <= sel_wdata;
            end
        end
    end

    // A write already registered when reset arrives must not reach the memory.
    assign mem_we = we_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q[0] <= TAG_IDLE;
            tag_q[1] <= TAG_IDLE;
        end else begin
            tag_q[0] <= '{valid: xfer, port: (gnt_b ? PORT_B : PORT_A)};
            tag_q[1] <= tag_q[0];
        end
    end

    assign a_rvalid = tag_q[1].valid && (tag_q[1].port == PORT_A);
    assign b_rvalid = tag_q[1].valid && (tag_q[1].port == PORT_B);
    assign a_rdata  = mem_out;
    assign b_rdata  = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin (dut0) and fixed-priority (dut1) arbiters, each with its own memory model.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;

    logic          a_ready0, a_rvalid0, b_ready0, b_rvalid0, mem_we0;
    logic [DW-1:0] a_rdata0, b_rdata0, mem_data0, mout0;
    logic [AW-1:0] mem_addr0;
    logic          a_ready1, a_rvalid1, b_ready1, b_rvalid1, mem_we1;
    logic [DW-1:0] a_rdata1, b_rdata1, mem_data1, mout1;
    logic [AW-1:0] mem_addr1;

    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_out(mout0)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_out(mout1)
    );

    // Single-port write-first memories with a registered output.
    always @(posedge clk) begin
        if (mem_we0) mem0[mem_addr0] <= mem_data0;
        mout0 <= mem_we0 ? mem_data0 : mem0[mem_addr0];
        if (mem_we1) mem1[mem_addr1] <= mem_data1;
        mout1 <= mem_we1 ? mem_data1 : mem1[mem_addr1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
        tick();
        #1;
        vec++; if (a_ready0 !== 1'b0) begin err++; $display("FAIL rst_a_ready0 got %b exp 0", a_ready0); end
        vec++; if (b_ready0 !== 1'b0) begin err++; $display("FAIL rst_b_ready0 got %b exp 0", b_ready0); end
        vec++; if (a_ready1 !== 1'b0) begin err++; $display("FAIL rst_a_ready1 got %b exp 0", a_ready1); end
        tick();
        vec++; if (mem_we0 !== 1'b0) begin err++; $display("FAIL rst_mem_we got %b exp 0", mem_we0); end
        vec++; if (mem_addr0 !== 6'd0) begin err++; $display("FAIL rst_mem_addr got %0d exp 0", mem_addr0); end
        vec++; if (mem_data0 !== 16'h0000) begin err++; $display("FAIL rst_mem_data got %h exp 0000", mem_data0); end
        vec++; if (a_rvalid0 !== 1'b0 || b_rvalid0 !== 1'b0) begin err++; $display("FAIL rst_rvalid got %b%b exp 00", a_rvalid0, b_rvalid0); end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    // Both ports hammer reads: dut0 alternates A,B,A,B; dut1 grants A until a_req drops.
    task automatic test_conflict();
        logic [1:0] g0 [8];
        logic [1:0] g1 [8];
        logic [1:0] r0, r1;
        g0 = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
        g1 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        a_we = 1'b0; b_we = 1'b0; a_addr = 6'd1; b_addr = 6'd2;
        for (int c = 0; c < 8; c++) begin
            a_req = (c < 4);
            b_req = (c < 5);
            #1;
            vec++; if (a_ready0 !== (g0[c] == 2'd1) || b_ready0 !== (g0[c] == 2'd2)) begin
                err++; $display("FAIL rr_grant c%0d got a%b b%b exp code %0d", c, a_ready0, b_ready0, g0[c]); end
            vec++; if (a_ready1 !== (g1[c] == 2'd1) || b_ready1 !== (g1[c] == 2'd2)) begin
                err++; $display("FAIL fixed_grant c%0d got a%b b%b exp code %0d", c, a_ready1, b_ready1, g1[c]); end
            r0 = (c >= 2) ? g0[c-2] : 2'd0;
            r1 = (c >= 2) ? g1[c-2] : 2'd0;
            vec++; if (a_rvalid0 !== (r0 == 2'd1) || b_rvalid0 !== (r0 == 2'd2)) begin
                err++; $display("FAIL rr_rvalid c%0d got a%b b%b exp code %0d", c, a_rvalid0, b_rvalid0, r0); end
            if (r0 != 2'd0) begin
                vec++; if (a_rdata0 !== ((r0 == 2'd1) ? 16'h1111 : 16'h2222)) begin
                    err++; $display("FAIL rr_rdata c%0d got %h exp code %0d", c, a_rdata0, r0); end
            end
            vec++; if (a_rvalid1 !== (r1 == 2'd1) || b_rvalid1 !== (r1 == 2'd2)) begin
                err++; $display("FAIL fixed_rvalid c%0d got a%b b%b exp code %0d", c, a_rvalid1, b_rvalid1, r1); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5;
        #1;
        vec++; if (a_ready0 !== 1'b1) begin err++; $display("FAIL rd_ready got %b exp 1", a_ready0); end
        tick();
        a_req = 1'b0;
        vec++; if (mem_addr0 !== 6'd5 || mem_we0 !== 1'b0) begin err++; $display("FAIL rd_issue got addr %0d we %b exp 5 0", mem_addr0, mem_we0); end
        vec++; if (a_rvalid0 !== 1'b0) begin err++; $display("FAIL rd_early got %b exp 0", a_rvalid0); end
        tick();
        vec++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h1234) begin err++; $display("FAIL rd_resp got v%b %h exp v1 1234", a_rvalid0, a_rdata0); end
        vec++; if (b_rvalid0 !== 1'b0) begin err++; $display("FAIL rd_b_rvalid got %b exp 0", b_rvalid0); end
        tick();
        vec++; if (a_rvalid0 !== 1'b0) begin err++; $display("FAIL rd_pulse got %b exp 0", a_rvalid0); end
        tick();
    endtask

    task automatic test_back_to_back();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd3; a_wdata = 16'hBEEF;
        #1;
        vec++; if (a_ready0 !== 1'b1) begin err++; $display("FAIL raw_wr_ready got %b exp 1", a_ready0); end
        tick();
        a_we = 1'b0;
        #1;
        vec++; if (a_ready0 !== 1'b1) begin err++; $display("FAIL raw_rd_ready got %b exp 1", a_ready0); end
        tick();
        a_req = 1'b0;
        vec++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'hBEEF) begin err++; $display("FAIL raw_wack got v%b %h exp v1 beef", a_rvalid0, a_rdata0); end
        tick();
        vec++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'hBEEF) begin err++; $display("FAIL raw_read got v%b %h exp v1 beef", a_rvalid0, a_rdata0); end
        tick();
        vec++; if (a_rvalid0 !== 1'b0) begin err++; $display("FAIL raw_tail got %b exp 0", a_rvalid0); end
    endtask

    task automatic test_reset_inflight();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd7; a_wdata = 16'hDEAD;
        #1;
        vec++; if (a_ready0 !== 1'b1) begin err++; $display("FAIL rif_ready got %b exp 1", a_ready0); end
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        vec++; if (mem_we0 !== 1'b0) begin err++; $display("FAIL rif_we_gated got %b exp 0", mem_we0); end
        tick();
        rst = 1'b0;
        vec++; if (mem_we0 !== 1'b0 || a_rvalid0 !== 1'b0) begin err++; $display("FAIL rif_post got we%b v%b exp 0 0", mem_we0, a_rvalid0); end
        tick();
        vec++; if (a_rvalid0 !== 1'b0) begin err++; $display("FAIL rif_no_rvalid got %b exp 0", a_rvalid0); end
        vec++; if (mem0[7] !== 16'h0777) begin err++; $display("FAIL rif_mem7 got %h exp 0777", mem0[7]); end
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd1;
        #1;
        vec++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b0) begin err++; $display("FAIL rif_conflict got a%b b%b exp a1 b0", a_ready0, b_ready0); end
        tick();
        idle_inputs();
        tick();
        vec++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h1234) begin err++; $display("FAIL rif_read got v%b %h exp v1 1234", a_rvalid0, a_rdata0); end
        tick();
        tick();
    endtask

    task automatic test_idle_then_b();
        for (int c = 0; c < 3; c++) begin
            vec++; if (mem_we0 !== 1'b0 || a_rvalid0 !== 1'b0 || b_rvalid0 !== 1'b0) begin
                err++; $display("FAIL idle c%0d got we%b a%b b%b exp 000", c, mem_we0, a_rvalid0, b_rvalid0); end
            tick();
        end
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
        #1;
        vec++; if (b_ready0 !== 1'b1 || a_ready0 !== 1'b0) begin err++; $display("FAIL idle_b_ready got b%b a%b exp b1 a0", b_ready0, a_ready0); end
        tick();
        idle_inputs();
        tick();
        vec++; if (b_rvalid0 !== 1'b1 || b_rdata0 !== 16'h2222 || a_rvalid0 !== 1'b0) begin
            err++; $display("FAIL idle_b_resp got v%b %h a%b exp v1 2222 a0", b_rvalid0, b_rdata0, a_rvalid0); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = {8'hA0, 2'b00, i[5:0]};
            mem1[i] = {8'hA0, 2'b00, i[5:0]};
        end
        mem0[1] = 16'h1111; mem0[2] = 16'h2222; mem0[5] = 16'h1234; mem0[7] = 16'h0777;
        mem1[1] = 16'h1111; mem1[2] = 16'h2222; mem1[5] = 16'h1234; mem1[7] = 16'h0777;
        test_reset();
        test_conflict();
        tick();
        test_read();
        test_back_to_back();
        test_reset_inflight();
        test_idle_then_b();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
